// File: rtl/latch_ctrl_pkg.sv
// Shared definitions for the latch write arbiter: FSM state encoding and
// default geometry of the latch bank and write pulse.
package latch_ctrl_pkg;

   localparam int DEF_WIDTH     = 4;
   localparam int DEF_PULSE_CYC = 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_PULSE = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie the requester not granted last wins.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       upd,
   output logic [1:0] gnt
);

   logic r_last;

   always_comb begin
      gnt = req;
      if (req == 2'b11) gnt = r_last ? 2'b01 : 2'b10;
   end

   // Pointer resets to "1 granted last" so req0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      r_last <= 1'b1;
      else if (upd) r_last <= gnt[1];
   end

endmodule

// File: rtl/latch_write_arbiter.sv
// Arbitrates two writers onto a shared gated-latch bank: SETUP, an enable
// pulse of PULSE_CYC cycles, then HOLD with ack and a readback check.
module latch_write_arbiter
   import latch_ctrl_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int PULSE_CYC = DEF_PULSE_CYC
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic [WIDTH-1:0] data0,
   input  logic [WIDTH-1:0] data1,
   input  logic [WIDTH-1:0] q,
   output logic             lat_en,
   output logic [WIDTH-1:0] lat_d,
   output logic             ack0,
   output logic             ack1,
   output logic             wr_err,
   output logic             busy,
   output logic [7:0]       err_cnt
);

   state_t           r_state;
   logic [3:0]       r_cnt;
   logic [1:0]       r_block;
   logic             r_gsel;
   logic             r_lat_en;
   logic [WIDTH-1:0] r_lat_d;
   logic             r_ack0;
   logic             r_ack1;
   logic             r_wr_err;
   logic             r_busy;
   logic [7:0]       r_err_cnt;

   logic [1:0]       w_elig;
   logic [1:0]       w_gnt;
   logic             w_upd;

   // The requester just acked sits out exactly one IDLE cycle.
   assign w_elig = {req1, req0} & ~r_block;
   assign w_upd  = (r_state == S_IDLE) && (|w_gnt);

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req (w_elig),
      .upd (w_upd),
      .gnt (w_gnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= 4'd0;
         r_block   <= 2'b00;
         r_gsel    <= 1'b0;
         r_lat_en  <= 1'b0;
         r_lat_d   <= '0;
         r_ack0    <= 1'b0;
         r_ack1    <= 1'b0;
         r_wr_err  <= 1'b0;
         r_busy    <= 1'b0;
         r_err_cnt <= 8'd0;
      end else begin
         r_ack0   <= 1'b0;
         r_ack1   <= 1'b0;
         r_wr_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_block <= 2'b00;
               if (|w_gnt) begin
                  r_lat_d <= w_gnt[1] ? data1 : data0;
                  r_gsel  <= w_gnt[1];
                  r_busy  <= 1'b1;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               r_lat_en <= 1'b1;
               r_cnt    <= 4'(PULSE_CYC - 1);
               r_state  <= S_PULSE;
            end
            S_PULSE: begin
               if (r_cnt == 4'd0) begin
                  // Readback is sampled at the closing edge of the pulse so
                  // wr_err lines up with ack in HOLD.
                  r_lat_en <= 1'b0;
                  r_ack0   <= ~r_gsel;
                  r_ack1   <= r_gsel;
                  if (q != r_lat_d) begin
                     r_wr_err <= 1'b1;
                     if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                  end
                  r_state <= S_HOLD;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_HOLD: begin
               r_block <= r_gsel ? 2'b10 : 2'b01;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign lat_en  = r_lat_en;
   assign lat_d   = r_lat_d;
   assign ack0    = r_ack0;
   assign ack1    = r_ack1;
   assign wr_err  = r_wr_err;
   assign busy    = r_busy;
   assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench: two arbiters (PULSE_CYC=1 and 3) each driving a model latch bank.
module tb_latch_write_arbiter;

   localparam int W = 4;
   localparam int P = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic [1:0]   rq;
   logic [W-1:0] dd [2];

   logic         lat_en_a, ack0_a, ack1_a, wr_err_a, busy_a, force_a;
   logic [W-1:0] lat_d_a, bank_a, q_a;
   logic [7:0]   err_cnt_a;
   logic         lat_en_b, ack0_b, ack1_b, wr_err_b, busy_b;
   logic [W-1:0] lat_d_b, bank_b, q_b;
   logic [7:0]   err_cnt_b;

   int total = 0;
   int bad   = 0;

   // transaction-level reference: mk = cycle index within the current write
   int           mk, mwho, mlast, mblock;
   logic [W-1:0] mdata;

   typedef struct {
      bit         rs;
      logic [1:0] rq;
      logic [3:0] d0, d1;
      logic [3:0] ex;   // busy, lat_en, ack0, ack1
      logic [3:0] latd;
   } vec_t;
   vec_t tbl [15];

   int   order [6];
   int   n, ovl, lat, nack;
   bit   got;
   logic err;
   logic [7:0] cnt;

   latch_write_arbiter u_a (
      .clk(clk), .rst(rst), .req0(rq[0]), .req1(rq[1]),
      .data0(dd[0]), .data1(dd[1]), .q(q_a),
      .lat_en(lat_en_a), .lat_d(lat_d_a), .ack0(ack0_a), .ack1(ack1_a),
      .wr_err(wr_err_a), .busy(busy_a), .err_cnt(err_cnt_a)
   );

   latch_write_arbiter #(.WIDTH(W), .PULSE_CYC(3)) u_b (
      .clk(clk), .rst(rst), .req0(rq[0]), .req1(rq[1]),
      .data0(dd[0]), .data1(dd[1]), .q(q_b),
      .lat_en(lat_en_b), .lat_d(lat_d_b), .ack0(ack0_b), .ack1(ack1_b),
      .wr_err(wr_err_b), .busy(busy_b), .err_cnt(err_cnt_b)
   );

   always_latch if (lat_en_a) bank_a <= lat_d_a;
   always_latch if (lat_en_b) bank_b <= lat_d_b;
   assign q_a = force_a ? '0 : bank_a;
   assign q_b = bank_b;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rq  = 2'b00;
      rst = 1'b1;
      #1;
      chk("reset state", {lat_en_a, lat_d_a, ack0_a, ack1_a, wr_err_a, busy_a, err_cnt_a,
                          lat_en_b, lat_d_b, ack0_b, ack1_b, wr_err_b, busy_b, err_cnt_b}, '0);
      @(posedge clk);
      #1;
      rst    = 1'b0;
      mk     = 0;
      mlast  = 1;
      mblock = -1;
      mdata  = '0;
   endtask

   task automatic model_step;
      bit e0, e1;
      if (mk == 0) begin
         e0 = rq[0] && mblock != 0;
         e1 = rq[1] && mblock != 1;
         mblock = -1;
         if (e0 || e1) begin
            mwho  = (e0 && e1) ? 1 - mlast : (e1 ? 1 : 0);
            mlast = mwho;
            mdata = dd[mwho];
            mk    = 1;
         end
      end else if (mk == 2 + P) begin
         mk     = 0;
         mblock = mwho;
      end else begin
         mk++;
      end
   endtask

   task automatic write0(input logic [W-1:0] d, output bit g, output logic e, output logic [7:0] c8);
      rq[0] = 1'b1;
      dd[0] = d;
      g = 1'b0; e = 1'b0; c8 = '0;
      for (int c = 0; c < 20 && !g; c++) begin
         tick();
         if (ack0_a) begin
            g = 1'b1; e = wr_err_a; c8 = err_cnt_a;
         end
      end
      rq[0] = 1'b0;
      tick();
   endtask

   initial begin
      force_a = 1'b0;
      dd[0] = '0;
      dd[1] = '0;
      do_reset();

      //              rs    rq     d0    d1    ex       latd
      tbl[0]  = '{1'b1, 2'b01, 4'hA, 4'h0, 4'b1000, 4'hA};
      tbl[1]  = '{1'b0, 2'b01, 4'hA, 4'h0, 4'b1100, 4'hA};
      tbl[2]  = '{1'b0, 2'b01, 4'hA, 4'h0, 4'b1010, 4'hA};
      tbl[3]  = '{1'b0, 2'b01, 4'hA, 4'h0, 4'b0000, 4'hA};
      tbl[4]  = '{1'b0, 2'b01, 4'hA, 4'h0, 4'b0000, 4'hA};
      tbl[5]  = '{1'b0, 2'b00, 4'hA, 4'h0, 4'b0000, 4'hA};
      tbl[6]  = '{1'b1, 2'b11, 4'h3, 4'hC, 4'b1000, 4'h3};
      tbl[7]  = '{1'b0, 2'b11, 4'hF, 4'hC, 4'b1100, 4'h3};
      tbl[8]  = '{1'b0, 2'b11, 4'hF, 4'hC, 4'b1010, 4'h3};
      tbl[9]  = '{1'b0, 2'b10, 4'hF, 4'hC, 4'b0000, 4'h3};
      tbl[10] = '{1'b0, 2'b10, 4'hF, 4'hC, 4'b1000, 4'hC};
      tbl[11] = '{1'b0, 2'b10, 4'hF, 4'hC, 4'b1100, 4'hC};
      tbl[12] = '{1'b0, 2'b10, 4'hF, 4'hC, 4'b1001, 4'hC};
      tbl[13] = '{1'b0, 2'b00, 4'hF, 4'hC, 4'b0000, 4'hC};
      tbl[14] = '{1'b0, 2'b00, 4'hF, 4'hC, 4'b0000, 4'hC};

      for (int i = 0; i < 15; i++) begin
         if (tbl[i].rs) do_reset();
         rq    = tbl[i].rq;
         dd[0] = tbl[i].d0;
         dd[1] = tbl[i].d1;
         tick();
         chk($sformatf("vec%0d", i), {busy_a, lat_en_a, ack0_a, ack1_a, lat_d_a, wr_err_a},
             {tbl[i].ex, tbl[i].latd, 1'b0});
         if (tbl[i].ex[1] || tbl[i].ex[0]) chk($sformatf("vec%0d q", i), q_a, tbl[i].latd);
      end

      // fairness with both requests held continuously
      do_reset();
      rq = 2'b11; dd[0] = 4'h5; dd[1] = 4'h6;
      n = 0; ovl = 0;
      for (int i = 0; i < 6; i++) order[i] = -1;
      for (int c = 0; c < 100 && n < 6; c++) begin
         tick();
         if (ack0_a && ack1_a) ovl++;
         else if (ack0_a) begin order[n] = 0; n++; end
         else if (ack1_a) begin order[n] = 1; n++; end
      end
      chk("fair acks", n, 6);
      chk("fair overlap", ovl, 0);
      for (int i = 0; i < 6; i++) chk($sformatf("fair order%0d", i), order[i], i % 2);

      // readback fault and counter saturation
      do_reset();
      force_a = 1'b1;
      write0(4'h5, got, err, cnt);
      chk("fault ack", got, 1);
      chk("fault wr_err", err, 1);
      chk("fault cnt1", cnt, 1);
      for (int i = 0; i < 299; i++) write0(W'(i), got, err, cnt);
      chk("fault cnt sat", err_cnt_a, 255);
      force_a = 1'b0;
      write0(4'h7, got, err, cnt);
      chk("clean after sat", {got, err, cnt}, {1'b1, 1'b0, 8'hFF});

      // reset during PULSE on the PULSE_CYC=3 instance
      do_reset();
      rq = 2'b01; dd[0] = 4'h9;
      tick();
      tick();
      chk("p3 pulse1 en", lat_en_b, 1);
      tick();
      chk("p3 pulse2 en", lat_en_b, 1);
      rst = 1'b1;
      rq  = 2'b00;
      #1;
      chk("p3 async drop", {lat_en_b, busy_b, ack0_b, ack1_b}, 4'b0000);
      rst = 1'b0;
      nack = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (ack0_b || ack1_b) nack++;
      end
      chk("p3 no ack", nack, 0);
      chk("p3 idle", {busy_b, err_cnt_b}, 9'd0);
      rq = 2'b11; dd[0] = 4'h3; dd[1] = 4'hC;
      got = 1'b0; lat = 0; n = 0;
      for (int c = 1; c <= 20 && !got; c++) begin
         tick();
         if (ack0_b || ack1_b) begin
            got = 1'b1; lat = c;
            n = {ack1_b, ack0_b};
            cnt = {3'b0, wr_err_b, q_b};
         end
      end
      chk("p3 tie ack", n, 1);
      chk("p3 latency", lat, 5);
      chk("p3 q/err", cnt, 8'h03);

      // randomized traffic against the reference model
      rq = 2'b00;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         @(posedge clk);
         model_step();
         #1;
         chk($sformatf("rand cyc%0d", c), {busy_a, lat_en_a, ack0_a, ack1_a, lat_d_a, wr_err_a},
             {mk != 0, mk >= 2 && mk <= 1 + P, mk == 2 + P && mwho == 0,
              mk == 2 + P && mwho == 1, mdata, 1'b0});
         if (mk == 2 + P) chk($sformatf("rand q%0d", c), q_a, mdata);
         for (int i = 0; i < 2; i++) begin
            if (rq[i]) begin
               if (mk == 2 + P && mwho == i && $urandom_range(0, 3) != 0) rq[i] = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
               rq[i] = 1'b1;
               dd[i] = W'($urandom);
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
